// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder: valid/ready word input, MSB-first serial output,
// one bit per DIV clocks, with a one-word holding register for gapless streaming.
module serial_word_feeder #(
    parameter int unsigned WIDTH    = 15,
    parameter int unsigned DIV      = 1,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             bit_strobe,
    output logic             word_done,
    output logic             busy
);
    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;

    logic             accept;
    logic             div_end;
    logic             have_next;
    logic [WIDTH-1:0] next_word;

    assign in_ready  = !rst && !hold_full;
    assign accept    = in_valid && in_ready;
    assign div_end   = (div_cnt == DIV_LAST);
    // The hold register always outranks a word arriving on the same edge.
    assign have_next = hold_full || accept;
    assign next_word = hold_full ? hold : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shifter    <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            serial_out <= IDLE_BIT;
            bit_strobe <= 1'b0;
            word_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            word_done  <= 1'b0;
            case (state)
                IDLE: begin
                    serial_out <= IDLE_BIT;
                    busy       <= 1'b0;
                    if (have_next) begin
                        shifter    <= next_word;
                        serial_out <= next_word[WIDTH-1];
                        bit_cnt    <= BIT_LAST;
                        div_cnt    <= '0;
                        bit_strobe <= 1'b1;
                        busy       <= 1'b1;
                        hold_full  <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    busy <= 1'b1;
                    if (div_end && bit_cnt == '0) begin
                        word_done <= 1'b1;
                        div_cnt   <= '0;
                        if (have_next) begin
                            shifter    <= next_word;
                            serial_out <= next_word[WIDTH-1];
                            bit_cnt    <= BIT_LAST;
                            bit_strobe <= 1'b1;
                            // Hold drained into the shifter; refill it if a word lands together.
                            hold_full  <= hold_full && accept;
                            if (hold_full && accept)
                                hold <= in_data;
                        end else begin
                            serial_out <= IDLE_BIT;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        if (accept) begin
                            hold      <= in_data;
                            hold_full <= 1'b1;
                        end
                        if (div_end) begin
                            div_cnt    <= '0;
                            shifter    <= {shifter[WIDTH-2:0], 1'b0};
                            serial_out <= shifter[WIDTH-2];
                            bit_cnt    <= bit_cnt - 1'b1;
                            bit_strobe <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= IDLE_BIT;
                    busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule
